// File: rtl/five_in_one_pkg.sv
// five_in_one_pkg
// Shared definitions for the five_in_one datapath: field widths, ALU opcode
// constants, next-PC and write-back select encodings, and the packed layouts
// of the two pipeline registers.
package five_in_one_pkg;

  localparam int DATA_W     = 8;
  localparam int PC_W       = 5;
  localparam int REG_ADDR_W = 2;
  localparam int IMM_W      = 4;
  localparam int MEM_ADDR_W = 4;
  localparam int NUM_REGS   = 4;
  localparam int MEM_DEPTH  = 16;
  localparam int OUT_W      = 7;

  // ALU opcodes; codes 11-15 are unnamed and pass A through
  typedef enum logic [3:0] {
    OP_PASS_B = 4'd0,
    OP_ADD    = 4'd1,
    OP_SUB    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_XOR    = 4'd5,
    OP_NOT_A  = 4'd6,
    OP_SHL    = 4'd7,
    OP_SHR    = 4'd8,
    OP_INC    = 4'd9,
    OP_DEC    = 4'd10
  } alu_op_e;

  // Next-PC select encodings
  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'b00,
    PC_SEL_TARGET = 2'b01,
    PC_SEL_LR     = 2'b10,
    PC_SEL_ZERO   = 2'b11
  } pc_sel_e;

  // Write-back select encodings
  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_LR  = 2'b10,
    WB_SEL_IN  = 2'b11
  } wb_sel_e;

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     store;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic [DATA_W-1:0]     value;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

endpackage

// File: rtl/five_in_one_alu.sv
// five_in_one_alu
// Purely combinational 8-bit ALU. All arithmetic is modulo 256 with the
// carry discarded.
// Ports:
//   op_i     - 4-bit operation code (see alu_op_e)
//   a_i      - operand A
//   b_i      - operand B
//   result_o - 8-bit result
module five_in_one_alu
  import five_in_one_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  // Operation decode; any unnamed opcode passes A through unchanged
  always_comb begin
    result_o = a_i;
    case (op_i)
      OP_PASS_B: result_o = b_i;
      OP_ADD:    result_o = a_i + b_i;
      OP_SUB:    result_o = a_i - b_i;
      OP_AND:    result_o = a_i & b_i;
      OP_OR:     result_o = a_i | b_i;
      OP_XOR:    result_o = a_i ^ b_i;
      OP_NOT_A:  result_o = ~a_i;
      OP_SHL:    result_o = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR:    result_o = {1'b0, a_i[DATA_W-1:1]};
      OP_INC:    result_o = a_i + 8'd1;
      OP_DEC:    result_o = a_i - 8'd1;
      default:   result_o = a_i;
    endcase
  end

endmodule

// File: rtl/five_in_one.sv
// five_in_one
// Externally sequenced five-stage datapath: PC/LR/IR fetch state, a 4x8
// register file, the ALU with N/Z flags, an EX/MEM register, a 16x8 data
// memory and a MEM/WB register feeding register write-back. Every stage is
// driven by its own enable, so all updates happen on one edge from pre-edge
// values.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   in           - instruction / input-port byte
//   PCCR, mux1CR - PC (and IR) load enable, next-PC select
//   LRCR         - link register load (LR <= PC+1)
//   RegCR        - register-file write enable
//   mux2CR       - ALU B select (R[rs] or zero-extended imm4)
//   OPALU        - ALU opcode
//   NFCR, ZFCR   - negative/zero flag update enables
//   Reg1CR       - EX/MEM load enable
//   DMCR         - data memory write enable
//   Reg2CR       - MEM/WB load enable
//   WBCR         - write-back select
//   Oi           - current PC
//   IFgn, IFgz   - registered N and Z flags
//   Reg1_out     - EX/MEM ALU result bits [6:0]
//   Reg2_out     - MEM/WB value bits [6:0]
module five_in_one
  import five_in_one_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              PCCR,
  input  logic [1:0]        mux1CR,
  input  logic              LRCR,
  input  logic              RegCR,
  input  logic              mux2CR,
  input  logic [3:0]        OPALU,
  input  logic              NFCR,
  input  logic              ZFCR,
  input  logic              Reg1CR,
  input  logic              DMCR,
  input  logic              Reg2CR,
  input  logic [1:0]        WBCR,
  output logic [PC_W-1:0]   Oi,
  output logic              IFgn,
  output logic              IFgz,
  output logic [OUT_W-1:0]  Reg1_out,
  output logic [OUT_W-1:0]  Reg2_out
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   lr_q, lr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              negFlag_q, negFlag_d;
  logic              zeroFlag_q, zeroFlag_d;
  ex_mem_t           exMem_q, exMem_d;
  mem_wb_t           memWb_q, memWb_d;

  logic [DATA_W-1:0] regFile_q [NUM_REGS];
  logic [DATA_W-1:0] dataMem_q [MEM_DEPTH];

  logic [REG_ADDR_W-1:0] rdField;
  logic [REG_ADDR_W-1:0] rsField;
  logic [IMM_W-1:0]      immField;
  logic [PC_W-1:0]       pcPlusOne;
  logic [DATA_W-1:0]     opA;
  logic [DATA_W-1:0]     opB;
  logic [DATA_W-1:0]     aluResult;
  logic [DATA_W-1:0]     memReadData;
  logic [MEM_ADDR_W-1:0] memAddr;

  // Instruction fields come from the latched IR, never directly from in
  assign rdField  = ir_q[7:6];
  assign rsField  = ir_q[5:4];
  assign immField = ir_q[3:0];

  // PC+1 naturally wraps 31 -> 0 in the 5-bit adder
  assign pcPlusOne = pc_q + 5'd1;

  // Register reads are combinational and see only pre-edge contents, so a
  // write on the same edge is not forwarded
  assign opA = regFile_q[rdField];
  assign opB = mux2CR ? {{(DATA_W-IMM_W){1'b0}}, immField} : regFile_q[rsField];

  five_in_one_alu u_alu (
    .op_i     (OPALU),
    .a_i      (opA),
    .b_i      (opB),
    .result_o (aluResult)
  );

  // Data memory is addressed by the low nibble of the EX/MEM ALU result
  assign memAddr     = exMem_q.alu[MEM_ADDR_W-1:0];
  assign memReadData = dataMem_q[memAddr];

  // Next-state for fetch state, flags and pipeline registers; each enable
  // acts independently and holds its register when low
  always_comb begin
    pc_d       = pc_q;
    lr_d       = lr_q;
    ir_d       = ir_q;
    negFlag_d  = negFlag_q;
    zeroFlag_d = zeroFlag_q;
    exMem_d    = exMem_q;
    memWb_d    = memWb_q;

    if (PCCR) begin
      ir_d = in;
      case (mux1CR)
        PC_SEL_INC:    pc_d = pcPlusOne;
        PC_SEL_TARGET: pc_d = in[PC_W-1:0];
        PC_SEL_LR:     pc_d = lr_q;
        PC_SEL_ZERO:   pc_d = '0;
        default:       pc_d = pc_q;
      endcase
    end

    if (LRCR) begin
      lr_d = pcPlusOne;
    end

    if (NFCR) begin
      negFlag_d = aluResult[DATA_W-1];
    end
    if (ZFCR) begin
      zeroFlag_d = (aluResult == '0);
    end

    if (Reg1CR) begin
      exMem_d.alu   = aluResult;
      exMem_d.store = regFile_q[rsField];
      exMem_d.rd    = rdField;
    end

    if (Reg2CR) begin
      case (WBCR)
        WB_SEL_ALU: memWb_d.value = exMem_q.alu;
        WB_SEL_MEM: memWb_d.value = memReadData;
        WB_SEL_LR:  memWb_d.value = {{(DATA_W-PC_W){1'b0}}, lr_q};
        WB_SEL_IN:  memWb_d.value = in;
        default:    memWb_d.value = memWb_q.value;
      endcase
      memWb_d.rd = exMem_q.rd;
    end
  end

  // Scalar state registers; reset overrides every enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      lr_q       <= '0;
      ir_q       <= '0;
      negFlag_q  <= 1'b0;
      zeroFlag_q <= 1'b0;
      exMem_q    <= '0;
      memWb_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      lr_q       <= lr_d;
      ir_q       <= ir_d;
      negFlag_q  <= negFlag_d;
      zeroFlag_q <= zeroFlag_d;
      exMem_q    <= exMem_d;
      memWb_q    <= memWb_d;
    end
  end

  // Register file write-back from MEM/WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (RegCR) begin
      regFile_q[memWb_q.rd] <= memWb_q.value;
    end
  end

  // Data memory is built from resettable flops so it clears with rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        dataMem_q[i] <= '0;
      end
    end else if (DMCR) begin
      dataMem_q[memAddr] <= exMem_q.store;
    end
  end

  assign Oi       = pc_q;
  assign IFgn     = negFlag_q;
  assign IFgz     = zeroFlag_q;
  assign Reg1_out = exMem_q.alu[OUT_W-1:0];
  assign Reg2_out = memWb_q.value[OUT_W-1:0];

endmodule

// File: tb/tb_five_in_one.sv
// tb_five_in_one
// Directed-vector bench for five_in_one. Control words are set, one clock
// edge is applied, and outputs are compared #1 after the edge against
// hand-computed values.
module tb_five_in_one;

  logic       clk;
  logic       rst;
  logic [7:0] inByte;
  logic       PCCR;
  logic [1:0] mux1CR;
  logic       LRCR;
  logic       RegCR;
  logic       mux2CR;
  logic [3:0] OPALU;
  logic       NFCR;
  logic       ZFCR;
  logic       Reg1CR;
  logic       DMCR;
  logic       Reg2CR;
  logic [1:0] WBCR;
  logic [4:0] Oi;
  logic       IFgn;
  logic       IFgz;
  logic [6:0] Reg1_out;
  logic [6:0] Reg2_out;

  int checkCount;
  int errorCount;

  typedef struct {
    logic [3:0] op;
    logic [7:0] result;
  } aluVec_t;

  // A = R0 = 0x2A, B = imm4 = 3; last entry leaves N set for the hold test
  aluVec_t aluTable [11] = '{
    '{4'd1,  8'h2D},
    '{4'd2,  8'h27},
    '{4'd3,  8'h02},
    '{4'd4,  8'h2B},
    '{4'd5,  8'h29},
    '{4'd7,  8'h54},
    '{4'd8,  8'h15},
    '{4'd9,  8'h2B},
    '{4'd0,  8'h03},
    '{4'd15, 8'h2A},
    '{4'd6,  8'hD5}
  };

  five_in_one dut (
    .clk      (clk),
    .rst      (rst),
    .in       (inByte),
    .PCCR     (PCCR),
    .mux1CR   (mux1CR),
    .LRCR     (LRCR),
    .RegCR    (RegCR),
    .mux2CR   (mux2CR),
    .OPALU    (OPALU),
    .NFCR     (NFCR),
    .ZFCR     (ZFCR),
    .Reg1CR   (Reg1CR),
    .DMCR     (DMCR),
    .Reg2CR   (Reg2CR),
    .WBCR     (WBCR),
    .Oi       (Oi),
    .IFgn     (IFgn),
    .IFgz     (IFgz),
    .Reg1_out (Reg1_out),
    .Reg2_out (Reg2_out)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Drop every control input back to its idle value
  task automatic clearControls();
    inByte = 8'h00;
    PCCR   = 1'b0;
    mux1CR = 2'b00;
    LRCR   = 1'b0;
    RegCR  = 1'b0;
    mux2CR = 1'b0;
    OPALU  = 4'd0;
    NFCR   = 1'b0;
    ZFCR   = 1'b0;
    Reg1CR = 1'b0;
    DMCR   = 1'b0;
    Reg2CR = 1'b0;
    WBCR   = 2'b00;
  endtask

  // Apply the current control word across one rising edge, then go idle
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearControls();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    clearControls();

    // Reset state
    #3;
    checkOutput("reset Oi",       {3'b0, Oi},   8'h00);
    checkOutput("reset IFgn",     {7'b0, IFgn}, 8'h00);
    checkOutput("reset IFgz",     {7'b0, IFgz}, 8'h00);
    checkOutput("reset Reg1_out", {1'b0, Reg1_out}, 8'h00);
    checkOutput("reset Reg2_out", {1'b0, Reg2_out}, 8'h00);
    applyStimulus();
    rst = 1'b0;

    // Branch then increment
    inByte = 8'h0F; PCCR = 1'b1; mux1CR = 2'b01;
    applyStimulus();
    checkOutput("branch 15", {3'b0, Oi}, 8'd15);
    PCCR = 1'b1; mux1CR = 2'b00;
    applyStimulus();
    checkOutput("pc+1 16", {3'b0, Oi}, 8'd16);

    // Link and return
    inByte = 8'h05; PCCR = 1'b1; mux1CR = 2'b01;
    applyStimulus();
    checkOutput("branch 5", {3'b0, Oi}, 8'd5);
    inByte = 8'h14; PCCR = 1'b1; mux1CR = 2'b01; LRCR = 1'b1;
    applyStimulus();
    checkOutput("call 20", {3'b0, Oi}, 8'd20);
    PCCR = 1'b1; mux1CR = 2'b10;
    applyStimulus();
    checkOutput("return 6", {3'b0, Oi}, 8'd6);
    PCCR = 1'b1; mux1CR = 2'b11;
    applyStimulus();
    checkOutput("pc zero", {3'b0, Oi}, 8'd0);

    // PC wrap 31 -> 0 (IR ends up 0x00)
    inByte = 8'h1F; PCCR = 1'b1; mux1CR = 2'b01;
    applyStimulus();
    checkOutput("branch 31", {3'b0, Oi}, 8'd31);
    PCCR = 1'b1; mux1CR = 2'b00;
    applyStimulus();
    checkOutput("pc wrap", {3'b0, Oi}, 8'd0);

    // ALU and flags with R0 = 0, imm4 = 0
    mux2CR = 1'b1; OPALU = 4'd1; Reg1CR = 1'b1; NFCR = 1'b1; ZFCR = 1'b1;
    applyStimulus();
    checkOutput("add zero res", {1'b0, Reg1_out}, 8'h00);
    checkOutput("add zero Z",   {7'b0, IFgz},     8'h01);
    checkOutput("add zero N",   {7'b0, IFgn},     8'h00);
    mux2CR = 1'b1; OPALU = 4'd10; Reg1CR = 1'b1; NFCR = 1'b1; ZFCR = 1'b1;
    applyStimulus();
    checkOutput("dec res", {1'b0, Reg1_out}, 8'h7F);
    checkOutput("dec N",   {7'b0, IFgn},     8'h01);
    checkOutput("dec Z",   {7'b0, IFgz},     8'h00);

    // Write-back of the input port into R0
    WBCR = 2'b11; inByte = 8'h2A; Reg2CR = 1'b1;
    applyStimulus();
    checkOutput("wb in", {1'b0, Reg2_out}, 8'h2A);
    RegCR = 1'b1;
    applyStimulus();
    OPALU = 4'd11; Reg1CR = 1'b1; NFCR = 1'b1; ZFCR = 1'b1;
    applyStimulus();
    checkOutput("R0 readback", {1'b0, Reg1_out}, 8'h2A);
    checkOutput("R0 readback N", {7'b0, IFgn}, 8'h00);

    // Load IR = 0x03 (rd0, rs0, imm 3) and sweep ALU ops
    inByte = 8'h03; PCCR = 1'b1;
    applyStimulus();
    for (int i = 0; i < 11; i++) begin
      mux2CR = 1'b1; OPALU = aluTable[i].op; Reg1CR = 1'b1; NFCR = 1'b1; ZFCR = 1'b1;
      applyStimulus();
      checkOutput($sformatf("alu op%0d res", aluTable[i].op), {1'b0, Reg1_out},
                  {1'b0, aluTable[i].result[6:0]});
      checkOutput($sformatf("alu op%0d N", aluTable[i].op), {7'b0, IFgn},
                  {7'b0, aluTable[i].result[7]});
    end

    // R0 - R0 = 0 with only Z enabled: N must hold its previous 1
    mux2CR = 1'b0; OPALU = 4'd2; Reg1CR = 1'b1; ZFCR = 1'b1;
    applyStimulus();
    checkOutput("sub reg res", {1'b0, Reg1_out}, 8'h00);
    checkOutput("sub reg Z",   {7'b0, IFgz},     8'h01);
    checkOutput("N hold",      {7'b0, IFgn},     8'h01);

    // Put 0x55 into R1 via IR = 0x43 (rd1)
    inByte = 8'h43; PCCR = 1'b1;
    applyStimulus();
    mux2CR = 1'b1; OPALU = 4'd0; Reg1CR = 1'b1;
    applyStimulus();
    checkOutput("exmem imm", {1'b0, Reg1_out}, 8'h03);
    WBCR = 2'b11; inByte = 8'h55; Reg2CR = 1'b1;
    applyStimulus();
    RegCR = 1'b1;
    applyStimulus();

    // Store R1 at address 3 via IR = 0x13 (rs1, imm 3)
    inByte = 8'h13; PCCR = 1'b1;
    applyStimulus();
    mux2CR = 1'b1; OPALU = 4'd0; Reg1CR = 1'b1;
    applyStimulus();
    WBCR = 2'b01; Reg2CR = 1'b1;
    applyStimulus();
    checkOutput("mem before store", {1'b0, Reg2_out}, 8'h00);
    DMCR = 1'b1;
    applyStimulus();
    WBCR = 2'b01; Reg2CR = 1'b1;
    applyStimulus();
    checkOutput("mem load", {1'b0, Reg2_out}, 8'h55);
    WBCR = 2'b10; Reg2CR = 1'b1;
    applyStimulus();
    checkOutput("wb lr", {1'b0, Reg2_out}, 8'h06);
    WBCR = 2'b00; Reg2CR = 1'b1;
    applyStimulus();
    checkOutput("wb alu", {1'b0, Reg2_out}, 8'h03);

    // Mid-operation reset with every enable asserted
    PCCR = 1'b1; LRCR = 1'b1; RegCR = 1'b1; Reg1CR = 1'b1; Reg2CR = 1'b1;
    DMCR = 1'b1; NFCR = 1'b1; ZFCR = 1'b1; OPALU = 4'd9; inByte = 8'h7F;
    rst = 1'b1;
    #1;
    checkOutput("async rst Oi",   {3'b0, Oi},   8'h00);
    checkOutput("async rst IFgn", {7'b0, IFgn}, 8'h00);
    checkOutput("async rst IFgz", {7'b0, IFgz}, 8'h00);
    checkOutput("async rst Reg1", {1'b0, Reg1_out}, 8'h00);
    checkOutput("async rst Reg2", {1'b0, Reg2_out}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("rst hold Oi", {3'b0, Oi}, 8'h00);
    rst = 1'b0;
    clearControls();
    PCCR = 1'b1; mux1CR = 2'b00;
    applyStimulus();
    checkOutput("resume pc", {3'b0, Oi}, 8'h01);
    OPALU = 4'd9; Reg1CR = 1'b1;
    applyStimulus();
    checkOutput("R0 cleared", {1'b0, Reg1_out}, 8'h01);
    inByte = 8'h03; PCCR = 1'b1;
    applyStimulus();
    mux2CR = 1'b1; OPALU = 4'd0; Reg1CR = 1'b1;
    applyStimulus();
    WBCR = 2'b01; Reg2CR = 1'b1;
    applyStimulus();
    checkOutput("mem cleared", {1'b0, Reg2_out}, 8'h00);
    WBCR = 2'b10; Reg2CR = 1'b1;
    applyStimulus();
    checkOutput("lr cleared", {1'b0, Reg2_out}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
